// File: rtl/hitchhike_top.sv
// hitchhike_top: backscatter tag that waits out an excitation preamble, then
// drives the RF switch with a frequency-shift square wave phase-flipped by tag data.
module hitchhike_top #(
  parameter int SHIFT_HALF      = 2,
  parameter int PREAMBLE_CYCLES = 19200,
  parameter int BIT_CYCLES      = 100,
  parameter int NUM_BITS        = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger_signal,
  input  logic insig,
  output logic clock_out,
  output logic output_signal,
  output logic signal_into_switch,
  output logic output_data_rate
);
  localparam int DIVW = $clog2(SHIFT_HALF + 1);
  localparam int DLYW = $clog2(PREAMBLE_CYCLES + 1);
  localparam int CYCW = $clog2(BIT_CYCLES + 1);
  localparam int BITW = $clog2(NUM_BITS + 1);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SHIFT_HALF - 1);
  localparam logic [DLYW-1:0] DLY_LAST = DLYW'(PREAMBLE_CYCLES - 1);
  localparam logic [CYCW-1:0] CYC_LAST = CYCW'(BIT_CYCLES - 1);
  localparam logic [CYCW-1:0] CYC_HALF = CYCW'(BIT_CYCLES / 2);
  localparam logic [BITW-1:0] BIT_LAST = BITW'(NUM_BITS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, TX} state_t;

  state_t state, state_n;
  logic [1:0] trig_s, ins_s;
  logic trig_d;
  logic [DIVW-1:0] div_cnt;
  logic [DLYW-1:0] dly_cnt;
  logic [CYCW-1:0] cyc_cnt;
  logic [BITW-1:0] bit_cnt;
  logic trig_edge, div_wrap, dly_done, bit_end, last_bit, load;

  assign trig_edge = trig_s[1] & ~trig_d;
  assign div_wrap  = div_cnt == DIV_LAST;
  assign dly_done  = (state == WAIT) && (dly_cnt == DLY_LAST);
  assign bit_end   = (state == TX) && (cyc_cnt == CYC_LAST);
  assign last_bit  = bit_cnt == BIT_LAST;
  assign load      = dly_done || (bit_end && !last_bit);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = trig_edge ? WAIT : IDLE;
      WAIT:    state_n = dly_done ? TX : WAIT;
      TX:      state_n = (bit_end && last_bit) ? IDLE : TX;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      trig_s             <= '0;
      trig_d             <= 1'b0;
      ins_s              <= '0;
      div_cnt            <= '0;
      dly_cnt            <= '0;
      cyc_cnt            <= '0;
      bit_cnt            <= '0;
      clock_out          <= 1'b0;
      output_signal      <= 1'b0;
      signal_into_switch <= 1'b0;
      output_data_rate   <= 1'b0;
    end else begin
      trig_s             <= {trig_s[0], trigger_signal};
      trig_d             <= trig_s[1];
      ins_s              <= {ins_s[0], insig};
      div_cnt            <= div_wrap ? '0 : div_cnt + 1'b1;
      clock_out          <= clock_out ^ div_wrap;
      state              <= state_n;
      dly_cnt            <= (state == WAIT) ? dly_cnt + 1'b1 : '0;
      cyc_cnt            <= (state == TX && !bit_end) ? cyc_cnt + 1'b1 : '0;
      bit_cnt            <= (state == TX) ? bit_cnt + BITW'(bit_end) : '0;
      // Data bit is captured only at bit boundaries and dropped when TX ends.
      output_signal      <= load ? ins_s[1] : (state_n == TX) ? output_signal : 1'b0;
      signal_into_switch <= (state == TX) & (clock_out ^ output_signal);
      output_data_rate   <= (state == TX) & (cyc_cnt < CYC_HALF);
    end
  end
endmodule

// File: tb/tb_hitchhike_top.sv
// tb_hitchhike_top: directed bursts with a timing-formula model of the expected outputs.
module tb_hitchhike_top;
  localparam int SH  = 2;
  localparam int P   = 40;
  localparam int BIT = 10;
  localparam int NUM = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic trigger_signal = 1'b0;
  logic insig = 1'b0;
  logic clock_out, output_signal, signal_into_switch, output_data_rate;

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int k0 = -100000;
  int t0 = -100000;
  int ins_mode = 0;
  bit retrig = 1'b0;

  hitchhike_top #(
    .SHIFT_HALF(SH), .PREAMBLE_CYCLES(P), .BIT_CYCLES(BIT), .NUM_BITS(NUM)
  ) dut (
    .clock(clock), .reset(reset), .trigger_signal(trigger_signal), .insig(insig),
    .clock_out(clock_out), .output_signal(output_signal),
    .signal_into_switch(signal_into_switch), .output_data_rate(output_data_rate)
  );

  always #5 clock = ~clock;

  function automatic logic exp_clk(int n);
    return ((n / SH) % 2) == 1;
  endfunction

  function automatic logic ins_at(int n);
    if (ins_mode == 1) return 1'b1;
    if (ins_mode == 2) return (n + BIT / 2 >= t0) ? (((n + BIT / 2 - t0) / BIT) % 2 == 1) : 1'b0;
    return 1'b0;
  endfunction

  function automatic logic trig_at(int n);
    return (n >= k0 && n < k0 + 10) ||
           (retrig && ((n >= k0 + 20 && n < k0 + 25) || (n >= t0 + 30 && n < t0 + 35)));
  endfunction

  function automatic logic exp_os(int n);
    if (n < t0 || n >= t0 + NUM * BIT) return 1'b0;
    return ins_at(t0 + ((n - t0) / BIT) * BIT - 2);
  endfunction

  function automatic logic exp_odr(int n);
    if (n < t0 + 1 || n > t0 + NUM * BIT) return 1'b0;
    return ((n - 1 - t0) % BIT) < BIT / 2;
  endfunction

  function automatic logic exp_sis(int n);
    if (n < t0 + 1 || n > t0 + NUM * BIT) return 1'b0;
    return exp_clk(n - 1) ^ exp_os(n - 1);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %b expected %b", tag, ncyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    ncyc++;
  endtask

  task automatic chk_all();
    chk("clock_out", clock_out, exp_clk(ncyc));
    chk("output_signal", output_signal, exp_os(ncyc));
    chk("output_data_rate", output_data_rate, exp_odr(ncyc));
    chk("signal_into_switch", signal_into_switch, exp_sis(ncyc));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_clock_out"}, clock_out, 1'b0);
    chk({tag, "_output_signal"}, output_signal, 1'b0);
    chk({tag, "_output_data_rate"}, output_data_rate, 1'b0);
    chk({tag, "_signal_into_switch"}, signal_into_switch, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      trigger_signal = 1'b0;
      insig = 1'b0;
      step();
      chk_all();
    end
  endtask

  task automatic run_burst(input int mode, input bit rt, input int abort_at);
    ins_mode = mode;
    retrig = rt;
    k0 = ncyc;
    t0 = k0 + 3 + P;
    while (ncyc < t0 + NUM * BIT + 4) begin
      trigger_signal = trig_at(ncyc);
      insig = ins_at(ncyc);
      step();
      chk_all();
      if (abort_at >= 0 && ncyc == t0 + abort_at) begin
        reset = 1'b0;
        #1;
        chk_zero("abort_async");
        repeat (3) @(negedge clock);
        chk_zero("abort_held");
        trigger_signal = 1'b0;
        insig = 1'b0;
        t0 = -100000;
        k0 = -100000;
        reset = 1'b1;
        ncyc = 0;
        return;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk_zero("reset");
    reset = 1'b1;
    ncyc = 0;
    idle(1000);
    run_burst(0, 1'b0, -1);
    idle(20);
    run_burst(1, 1'b0, -1);
    idle(20);
    run_burst(2, 1'b0, -1);
    idle(20);
    run_burst(0, 1'b1, -1);
    run_burst(1, 1'b0, -1);
    run_burst(2, 1'b0, 3 * BIT + 4);
    idle(100);
    run_burst(1, 1'b0, -1);
    idle(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
